// File: rtl/guess_evaluator_pkg.sv
// Shared Wordle definitions: letter/colour codes, widths, FSM states and
// the packed board-cell payload.
package wordle_pkg;

  localparam int unsigned LETTER_W  = 5;
  localparam int unsigned COLOR_W   = 2;
  localparam int unsigned CELL_W    = LETTER_W + COLOR_W;
  localparam int unsigned WORD_LEN  = 5;
  localparam int unsigned WORD_W    = WORD_LEN * LETTER_W;
  localparam int unsigned ROW_W     = WORD_LEN * CELL_W;
  localparam int unsigned ROW_IDX_W = 3;

  localparam logic [LETTER_W-1:0] BLANK    = LETTER_W'(0);
  localparam logic [LETTER_W-1:0] LETTER_A = LETTER_W'(1);
  localparam logic [LETTER_W-1:0] LETTER_Z = LETTER_W'(26);

  localparam logic [COLOR_W-1:0] GREY   = COLOR_W'(0);
  localparam logic [COLOR_W-1:0] YELLOW = COLOR_W'(1);
  localparam logic [COLOR_W-1:0] GREEN  = COLOR_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GREEN,
    ST_YELLOW,
    ST_DONE,
    ST_END
  } state_t;

  typedef struct packed {
    logic [COLOR_W-1:0]  color;
    logic [LETTER_W-1:0] letter;
  } cell_t;

  // True when every cell holds a letter A..Z.
  function automatic logic word_valid(input logic [WORD_W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (w[i*LETTER_W +: LETTER_W] == BLANK || w[i*LETTER_W +: LETTER_W] > LETTER_Z)
        ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/guess_evaluator_if.sv
// Submit/result bus between the letter-selection stage and the evaluator.
interface guess_evaluator_if;
  import wordle_pkg::*;

  logic                 submit;
  logic [WORD_W-1:0]    guess;
  logic [WORD_W-1:0]    target;
  logic                 busy;
  logic                 reject;
  logic                 result_valid;
  logic [ROW_W-1:0]     result_row;
  logic [ROW_IDX_W-1:0] row_idx;
  logic                 win;
  logic                 game_over;

  modport master (
    output submit, guess, target,
    input  busy, reject, result_valid, result_row, row_idx, win, game_over
  );

  modport slave (
    input  submit, guess, target,
    output busy, reject, result_valid, result_row, row_idx, win, game_over
  );

endinterface

// File: rtl/guess_evaluator_yellow_scan.sv
// Priority finder: lowest unconsumed target position holding the given letter.
module yellow_scan
  import wordle_pkg::*;
(
  input  logic [LETTER_W-1:0] letter,
  input  logic [WORD_W-1:0]   target,
  input  logic [WORD_LEN-1:0] consumed,
  output logic                hit,
  output logic [WORD_LEN-1:0] match_onehot
);

  logic [WORD_LEN-1:0] cand;

  always_comb begin
    cand = '0;
    for (int j = 0; j < WORD_LEN; j++)
      cand[j] = !consumed[j] && (target[j*LETTER_W +: LETTER_W] == letter);
    // Isolate the lowest set bit.
    match_onehot = cand & (~cand + WORD_LEN'(1));
    hit          = |cand;
  end

endmodule

// File: rtl/guess_evaluator.sv
// Scores a guess against the target with Wordle duplicate rules and emits one
// coloured board row; tracks rows used, win and game-over.
module guess_evaluator
  import wordle_pkg::*;
#(
  parameter int unsigned MAX_GUESSES = 6
) (
  input  logic               clk,
  input  logic               rst,
  guess_evaluator_if.slave   bus
);

  state_t               state_q, state_d;
  logic [2:0]           pos_q, pos_d;
  logic [WORD_W-1:0]    guess_q, guess_d;
  logic [WORD_W-1:0]    target_q, target_d;
  logic [WORD_LEN-1:0][COLOR_W-1:0] color_q, color_d;
  logic [WORD_LEN-1:0]  consumed_q, consumed_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
  cell_t [WORD_LEN-1:0] result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 reject_q, reject_d;
  logic                 valid_q, valid_d;
  logic                 win_q, win_d;
  logic                 go_q, go_d;

  logic [LETTER_W-1:0]  g_let [WORD_LEN];
  logic [LETTER_W-1:0]  t_let [WORD_LEN];
  logic                 scan_hit;
  logic [WORD_LEN-1:0]  scan_onehot;

  always_comb begin
    for (int i = 0; i < WORD_LEN; i++) begin
      g_let[i] = guess_q[i*LETTER_W +: LETTER_W];
      t_let[i] = target_q[i*LETTER_W +: LETTER_W];
    end
  end

  yellow_scan u_scan (
    .letter       (g_let[pos_q]),
    .target       (target_q),
    .consumed     (consumed_q),
    .hit          (scan_hit),
    .match_onehot (scan_onehot)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    guess_d    = guess_q;
    target_d   = target_q;
    color_d    = color_q;
    consumed_d = consumed_q;
    row_d      = row_q;
    row_idx_d  = row_idx_q;
    result_d   = result_q;
    reject_d   = 1'b0;
    valid_d    = 1'b0;
    win_d      = win_q;
    go_d       = go_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.submit) begin
          if (!word_valid(bus.guess)) begin
            reject_d = 1'b1;
          end else begin
            guess_d    = bus.guess;
            target_d   = bus.target;
            consumed_d = '0;
            color_d    = '0;
            state_d    = ST_GREEN;
          end
        end
      end
      ST_GREEN: begin
        for (int i = 0; i < WORD_LEN; i++) begin
          if (g_let[i] == t_let[i]) begin
            color_d[i]    = GREEN;
            consumed_d[i] = 1'b1;
          end else begin
            color_d[i]    = GREY;
          end
        end
        pos_d   = 3'd0;
        state_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (color_q[pos_q] != GREEN && scan_hit) begin
          color_d[pos_q] = YELLOW;
          consumed_d     = consumed_q | scan_onehot;
        end
        if (pos_q == 3'(WORD_LEN - 1)) begin
          // Final colours are settled here, so load the result as DONE begins.
          state_d   = ST_DONE;
          valid_d   = 1'b1;
          row_idx_d = row_q;
          for (int i = 0; i < WORD_LEN; i++) begin
            result_d[i].color  = color_d[i];
            result_d[i].letter = g_let[i];
          end
          win_d = (color_d == {WORD_LEN{GREEN}});
          go_d  = win_d || (row_q == ROW_IDX_W'(MAX_GUESSES - 1));
        end else begin
          pos_d = pos_q + 3'd1;
        end
      end
      ST_DONE: begin
        row_d   = row_q + ROW_IDX_W'(1);
        state_d = go_q ? ST_END : ST_IDLE;
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_GREEN) || (state_d == ST_YELLOW) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      guess_q    <= '0;
      target_q   <= '0;
      color_q    <= '0;
      consumed_q <= '0;
      row_q      <= '0;
      row_idx_q  <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      reject_q   <= 1'b0;
      valid_q    <= 1'b0;
      win_q      <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      guess_q    <= guess_d;
      target_q   <= target_d;
      color_q    <= color_d;
      consumed_q <= consumed_d;
      row_q      <= row_d;
      row_idx_q  <= row_idx_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      reject_q   <= reject_d;
      valid_q    <= valid_d;
      win_q      <= win_d;
      go_q       <= go_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.reject       = reject_q;
  assign bus.result_valid = valid_q;
  assign bus.result_row   = result_q;
  assign bus.row_idx      = row_idx_q;
  assign bus.win          = win_q;
  assign bus.game_over    = go_q;

endmodule

// File: tb/tb_guess_evaluator.sv
// Self-checking bench for guess_evaluator: directed Wordle scenarios plus
// randomized guesses scored by a letter-count reference model.
module tb_guess_evaluator;
  import wordle_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  guess_evaluator_if bus();

  guess_evaluator #(.MAX_GUESSES(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [WORD_W-1:0] enc(input string s);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) w[i*5 +: 5] = 5'(s[i] - 8'd64);
    return w;
  endfunction

  // Reference: greens first, then yellows from a pool of unmatched target letters.
  function automatic logic [ROW_W-1:0] model_row(input logic [WORD_W-1:0] g, t);
    int cnt[32];
    logic [1:0] col[5];
    logic [4:0] gl[5];
    logic [4:0] tl[5];
    logic [ROW_W-1:0] r;
    for (int k = 0; k < 32; k++) cnt[k] = 0;
    for (int i = 0; i < 5; i++) begin
      gl[i] = g[i*5 +: 5];
      tl[i] = t[i*5 +: 5];
    end
    for (int i = 0; i < 5; i++) begin
      if (gl[i] == tl[i]) col[i] = 2'd2;
      else begin
        col[i] = 2'd0;
        cnt[tl[i]] = cnt[tl[i]] + 1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (col[i] != 2'd2 && cnt[gl[i]] > 0) begin
        col[i] = 2'd1;
        cnt[gl[i]] = cnt[gl[i]] - 1;
      end
    end
    r = '0;
    for (int i = 0; i < 5; i++) r[i*7 +: 7] = {col[i], gl[i]};
    return r;
  endfunction

  function automatic logic [9:0] colors_of(input logic [ROW_W-1:0] r);
    logic [9:0] c;
    for (int i = 0; i < 5; i++) c[i*2 +: 2] = r[i*7+5 +: 2];
    return c;
  endfunction

  function automatic logic model_valid(input logic [WORD_W-1:0] g);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++)
      if (g[i*5 +: 5] < 5'd1 || g[i*5 +: 5] > 5'd26) ok = 1'b0;
    return ok;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.submit = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Submit one guess and observe 12 cycles after the accept edge.
  task automatic run_guess(input logic [WORD_W-1:0] g, t, output int lat, output int nvalid,
                           output logic [ROW_W-1:0] row, output logic [2:0] ridx,
                           output logic w, output logic go, output logic rej1, output logic busy1);
    lat = -1; nvalid = 0; row = '0; ridx = '0; w = 1'b0; go = 1'b0; rej1 = 1'b0; busy1 = 1'b0;
    @(negedge clk);
    bus.submit = 1'b1; bus.guess = g; bus.target = t;
    @(posedge clk);
    #1;
    bus.submit = 1'b0;
    bus.guess  = 25'($urandom);
    bus.target = 25'($urandom);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin rej1 = bus.reject; busy1 = bus.busy; end
      if (bus.result_valid === 1'b1) begin
        nvalid++;
        if (lat < 0) begin
          lat = c; row = bus.result_row; ridx = bus.row_idx; w = bus.win; go = bus.game_over;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.reject !== 1'b0) begin n_err++; $display("FAIL reset_reject got=%b exp=0", bus.reject); end
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.result_valid); end
    n_cmp++; if (bus.result_row !== '0) begin n_err++; $display("FAIL reset_row got=%h exp=0", bus.result_row); end
    n_cmp++; if (bus.row_idx !== 3'd0) begin n_err++; $display("FAIL reset_row_idx got=%0d exp=0", bus.row_idx); end
    n_cmp++; if (bus.win !== 1'b0) begin n_err++; $display("FAIL reset_win got=%b exp=0", bus.win); end
    n_cmp++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL reset_game_over got=%b exp=0", bus.game_over); end
    rst = 1'b1;
  endtask

  task automatic test_exact();
    int lat, nv; logic [ROW_W-1:0] row; logic [2:0] ridx; logic w, go, rj, bz;
    apply_reset();
    run_guess(enc("CRANE"), enc("CRANE"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (bz !== 1'b1) begin n_err++; $display("FAIL exact_busy_k1 got=%b exp=1", bz); end
    n_cmp++; if (lat != 7) begin n_err++; $display("FAIL exact_latency got=%0d exp=7", lat); end
    n_cmp++; if (nv != 1) begin n_err++; $display("FAIL exact_valid_pulses got=%0d exp=1", nv); end
    n_cmp++; if (colors_of(row) !== 10'b10_10_10_10_10) begin n_err++; $display("FAIL exact_colors got=%b exp=%b", colors_of(row), 10'b10_10_10_10_10); end
    n_cmp++; if (row !== model_row(enc("CRANE"), enc("CRANE"))) begin n_err++; $display("FAIL exact_row got=%h exp=%h", row, model_row(enc("CRANE"), enc("CRANE"))); end
    n_cmp++; if (ridx !== 3'd0) begin n_err++; $display("FAIL exact_row_idx got=%0d exp=0", ridx); end
    n_cmp++; if (w !== 1'b1 || go !== 1'b1) begin n_err++; $display("FAIL exact_win_go got=%b%b exp=11", w, go); end
    run_guess(enc("SLATE"), enc("CRANE"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (bz !== 1'b0 || nv != 0) begin n_err++; $display("FAIL exact_after_end busy=%b valids=%0d exp=0/0", bz, nv); end
  endtask

  task automatic test_duplicates();
    int lat, nv; logic [ROW_W-1:0] row; logic [2:0] ridx; logic w, go, rj, bz;
    apply_reset();
    run_guess(enc("PAPAL"), enc("APPLE"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (colors_of(row) !== 10'b01_00_10_01_01) begin n_err++; $display("FAIL dup_papal got=%b exp=%b", colors_of(row), 10'b01_00_10_01_01); end
    n_cmp++; if (ridx !== 3'd0 || w !== 1'b0 || go !== 1'b0) begin n_err++; $display("FAIL dup_papal_status got=%0d/%b/%b exp=0/0/0", ridx, w, go); end
    run_guess(enc("EERIE"), enc("SPEED"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (colors_of(row) !== 10'b00_00_00_01_01) begin n_err++; $display("FAIL dup_eerie got=%b exp=%b", colors_of(row), 10'b00_00_00_01_01); end
    n_cmp++; if (ridx !== 3'd1) begin n_err++; $display("FAIL dup_eerie_row_idx got=%0d exp=1", ridx); end
  endtask

  task automatic test_reject();
    int lat, nv; logic [ROW_W-1:0] row; logic [2:0] ridx; logic w, go, rj, bz;
    logic [WORD_W-1:0] g;
    apply_reset();
    g = enc("CRANE");
    g[15 +: 5] = 5'd0;
    run_guess(g, enc("CRANE"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (rj !== 1'b1 || bz !== 1'b0) begin n_err++; $display("FAIL reject_blank rej=%b busy=%b exp=1/0", rj, bz); end
    n_cmp++; if (nv != 0) begin n_err++; $display("FAIL reject_blank_valid got=%0d exp=0", nv); end
    g = enc("CRANE");
    g[0 +: 5] = 5'd27;
    run_guess(g, enc("CRANE"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (rj !== 1'b1 || nv != 0) begin n_err++; $display("FAIL reject_27 rej=%b valids=%0d exp=1/0", rj, nv); end
    run_guess(enc("TRAIN"), enc("CRANE"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (nv != 1 || ridx !== 3'd0 || rj !== 1'b0) begin n_err++; $display("FAIL reject_then_valid valids=%0d row_idx=%0d rej=%b exp=1/0/0", nv, ridx, rj); end
  endtask

  task automatic test_exhaust();
    int lat, nv; logic [ROW_W-1:0] row; logic [2:0] ridx; logic w, go, rj, bz;
    logic [WORD_W-1:0] g;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 5; p++) g[p*5 +: 5] = 5'($urandom_range(6, 26));
      run_guess(g, enc("CRANE"), lat, nv, row, ridx, w, go, rj, bz);
      n_cmp++; if (ridx !== 3'(i) || nv != 1) begin n_err++; $display("FAIL exhaust_row_idx i=%0d got=%0d valids=%0d", i, ridx, nv); end
      n_cmp++; if (go !== (i == 5) || w !== 1'b0) begin n_err++; $display("FAIL exhaust_status i=%0d go=%b win=%b exp=%b/0", i, go, w, (i == 5)); end
      n_cmp++; if (row !== model_row(g, enc("CRANE"))) begin n_err++; $display("FAIL exhaust_row i=%0d got=%h exp=%h", i, row, model_row(g, enc("CRANE"))); end
    end
    run_guess(enc("CRANE"), enc("CRANE"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (bz !== 1'b0 || nv != 0) begin n_err++; $display("FAIL exhaust_seventh busy=%b valids=%0d exp=0/0", bz, nv); end
  endtask

  task automatic test_reset_mid();
    int lat, nv; logic [ROW_W-1:0] row; logic [2:0] ridx; logic w, go, rj, bz;
    int vcount;
    apply_reset();
    run_guess(enc("BLAST"), enc("CRANE"), lat, nv, row, ridx, w, go, rj, bz);
    vcount = 0;
    @(negedge clk);
    bus.submit = 1'b1; bus.guess = enc("CRANE"); bus.target = enc("CRANE");
    @(posedge clk);
    #1 bus.submit = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) vcount++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.reject !== 1'b0)
      begin n_err++; $display("FAIL midreset_ctrl busy=%b valid=%b rej=%b exp=000", bus.busy, bus.result_valid, bus.reject); end
    n_cmp++; if (bus.row_idx !== 3'd0 || bus.result_row !== '0 || bus.win !== 1'b0 || bus.game_over !== 1'b0)
      begin n_err++; $display("FAIL midreset_data row_idx=%0d row=%h win=%b go=%b exp=0", bus.row_idx, bus.result_row, bus.win, bus.game_over); end
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) vcount++;
    end
    n_cmp++; if (vcount != 0) begin n_err++; $display("FAIL midreset_no_result got=%0d exp=0", vcount); end
    run_guess(enc("PLANT"), enc("CRANE"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (ridx !== 3'd0 || nv != 1) begin n_err++; $display("FAIL midreset_row_restart got=%0d valids=%0d exp=0/1", ridx, nv); end
  endtask

  task automatic test_busy_submit();
    int lat, nv; logic [ROW_W-1:0] row; logic [2:0] ridx; logic w, go, rj, bz;
    int vcount;
    logic [ROW_W-1:0] first_row;
    apply_reset();
    vcount = 0; first_row = '0;
    @(negedge clk);
    bus.submit = 1'b1; bus.guess = enc("SLEEP"); bus.target = enc("SPEED");
    @(posedge clk);
    #1 bus.submit = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) begin
        vcount++;
        if (vcount == 1) first_row = bus.result_row;
      end
      if (c == 3) begin bus.submit = 1'b1; bus.guess = enc("SPEED"); end
      if (c == 4) bus.submit = 1'b0;
    end
    n_cmp++; if (vcount != 1) begin n_err++; $display("FAIL busy_submit_count got=%0d exp=1", vcount); end
    n_cmp++; if (first_row !== model_row(enc("SLEEP"), enc("SPEED"))) begin n_err++; $display("FAIL busy_submit_row got=%h exp=%h", first_row, model_row(enc("SLEEP"), enc("SPEED"))); end
    run_guess(enc("ABCDE"), enc("SPEED"), lat, nv, row, ridx, w, go, rj, bz);
    n_cmp++; if (ridx !== 3'd1) begin n_err++; $display("FAIL busy_submit_next_row got=%0d exp=1", ridx); end
  endtask

  task automatic test_random();
    int lat, nv; logic [ROW_W-1:0] row; logic [2:0] ridx; logic w, go, rj, bz;
    logic [4:0] alpha[5];
    logic [WORD_W-1:0] g, t;
    int m_row; logic m_win, m_go;
    alpha[0] = 5'd1; alpha[1] = 5'd2; alpha[2] = 5'd5; alpha[3] = 5'd12; alpha[4] = 5'd19;
    apply_reset();
    m_row = 0; m_win = 1'b0; m_go = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (m_go) begin
        apply_reset();
        m_row = 0; m_win = 1'b0; m_go = 1'b0;
      end
      for (int p = 0; p < 5; p++) begin
        g[p*5 +: 5] = alpha[$urandom_range(0, 4)];
        t[p*5 +: 5] = alpha[$urandom_range(0, 4)];
      end
      if ($urandom_range(0, 7) == 0)
        g[$urandom_range(0, 4)*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(27, 31));
      run_guess(g, t, lat, nv, row, ridx, w, go, rj, bz);
      if (!model_valid(g)) begin
        n_cmp++; if (rj !== 1'b1 || nv != 0) begin n_err++; $display("FAIL rand_reject it=%0d rej=%b valids=%0d exp=1/0", it, rj, nv); end
      end else begin
        m_win = (colors_of(model_row(g, t)) == 10'b10_10_10_10_10);
        m_go  = m_win || (m_row == 5);
        n_cmp++; if (lat != 7 || nv != 1) begin n_err++; $display("FAIL rand_timing it=%0d lat=%0d valids=%0d exp=7/1", it, lat, nv); end
        n_cmp++; if (row !== model_row(g, t)) begin n_err++; $display("FAIL rand_row it=%0d got=%h exp=%h", it, row, model_row(g, t)); end
        n_cmp++; if (ridx !== 3'(m_row) || w !== m_win || go !== m_go)
          begin n_err++; $display("FAIL rand_status it=%0d got=%0d/%b/%b exp=%0d/%b/%b", it, ridx, w, go, m_row, m_win, m_go); end
        m_row++;
      end
    end
  endtask

  initial begin
    bus.submit = 1'b0;
    bus.guess  = '0;
    bus.target = '0;
    test_reset();
    test_exact();
    test_duplicates();
    test_reject();
    test_exhaust();
    test_reset_mid();
    test_busy_submit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
